// File: rtl/mycpu_wb_stage_if.sv
// MEM -> WB handshake bundle: retiring instruction fields plus the WB accept signal.
interface mycpu_wb_stage_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  ms_to_ws_valid;
  logic [31:0]           ms_pc;
  logic                  ms_gr_we;
  logic [ADDR_WIDTH-1:0] ms_dest;
  logic [2:0]            ms_ld_op;
  logic [1:0]            ms_addr_low;
  logic [DATA_WIDTH-1:0] ms_result;
  logic                  ws_allowin;

  modport master (
    output ms_to_ws_valid, ms_pc, ms_gr_we, ms_dest, ms_ld_op, ms_addr_low, ms_result,
    input  ws_allowin
  );

  modport slave (
    input  ms_to_ws_valid, ms_pc, ms_gr_we, ms_dest, ms_ld_op, ms_addr_low, ms_result,
    output ws_allowin
  );
endinterface

// File: rtl/mycpu_wb_stage.sv
// Write-back stage: latches the MEM instruction, waits for load data, aligns it and
// drives the byte-strobed register-file write port, trace port and hazard status.
module mycpu_wb_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  mycpu_wb_stage_if.slave       ms,
  input  logic                  data_rvalid,
  input  logic [DATA_WIDTH-1:0] data_rdata,
  input  logic                  ws_flush,
  output logic [3:0]            rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic [ADDR_WIDTH-1:0] ws_dest,
  output logic                  ws_fwd_ok,
  output logic [31:0]           debug_wb_pc,
  output logic [3:0]            debug_wb_rf_wen,
  output logic [ADDR_WIDTH-1:0] debug_wb_rf_wnum,
  output logic [DATA_WIDTH-1:0] debug_wb_rf_wdata
);
  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_DRAIN} state_e;

  localparam logic [2:0] LD_NONE = 3'd0, LD_LB = 3'd1, LD_LBU = 3'd2, LD_LH = 3'd3,
                         LD_LHU = 3'd4, LD_LW = 3'd5, LD_LWL = 3'd6, LD_LWR = 3'd7;

  state_e                state_q, state_d;
  logic [31:0]           pc_q;
  logic                  gr_we_q;
  logic [ADDR_WIDTH-1:0] dest_q;
  logic [2:0]            ld_op_q;
  logic [1:0]            addr_low_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [ADDR_WIDTH-1:0] waddr_q;

  logic                  ready_go, retire, accept;
  logic [DATA_WIDTH-1:0] byte_sh, wdata_n;
  logic [15:0]           half;
  logic [3:0]            wen_n;

  assign ready_go      = (ld_op_q == LD_NONE) || data_rvalid;
  assign retire        = (state_q == S_HOLD) && ready_go && !ws_flush;
  assign ms.ws_allowin = (state_q == S_IDLE) || retire;
  assign accept        = ms.ms_to_ws_valid && ms.ws_allowin;

  always_comb begin
    byte_sh = data_rdata >> {addr_low_q, 3'b000};
    half    = addr_low_q[1] ? data_rdata[31:16] : data_rdata[15:0];
    wdata_n = result_q;
    wen_n   = 4'b1111;
    case (ld_op_q)
      LD_LB:   wdata_n = {{(DATA_WIDTH-8){byte_sh[7]}}, byte_sh[7:0]};
      LD_LBU:  wdata_n = {{(DATA_WIDTH-8){1'b0}}, byte_sh[7:0]};
      LD_LH:   wdata_n = {{(DATA_WIDTH-16){half[15]}}, half};
      LD_LHU:  wdata_n = {{(DATA_WIDTH-16){1'b0}}, half};
      LD_LW:   wdata_n = data_rdata;
      // LWL/LWR place the loaded bytes in their final lanes; wen picks the merged bytes.
      LD_LWL: begin
        wdata_n = data_rdata << {~addr_low_q, 3'b000};
        wen_n   = 4'b1111 << ~addr_low_q;
      end
      LD_LWR: begin
        wdata_n = data_rdata >> {addr_low_q, 3'b000};
        wen_n   = 4'b1111 >> addr_low_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (ms.ms_to_ws_valid) state_d = S_HOLD;
      S_HOLD: begin
        if (ws_flush)      state_d = (ld_op_q != LD_NONE && !data_rvalid) ? S_DRAIN : S_IDLE;
        else if (ready_go) state_d = ms.ms_to_ws_valid ? S_HOLD : S_IDLE;
      end
      S_DRAIN: if (data_rvalid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      gr_we_q    <= 1'b0;
      dest_q     <= '0;
      ld_op_q    <= LD_NONE;
      addr_low_q <= '0;
      result_q   <= '0;
      wdata_q    <= '0;
      waddr_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        pc_q       <= ms.ms_pc;
        gr_we_q    <= ms.ms_gr_we;
        dest_q     <= ms.ms_dest;
        ld_op_q    <= ms.ms_ld_op;
        addr_low_q <= ms.ms_addr_low;
        result_q   <= ms.ms_result;
      end
      if (retire) begin
        wdata_q <= wdata_n;
        waddr_q <= dest_q;
      end
    end
  end

  // Outside the retire cycle the write port replays the last retired value so it stays stable.
  assign rf_wen   = (retire && gr_we_q && dest_q != '0) ? wen_n : 4'b0000;
  assign rf_waddr = retire ? dest_q  : waddr_q;
  assign rf_wdata = retire ? wdata_n : wdata_q;

  assign ws_dest   = (state_q == S_HOLD && gr_we_q) ? dest_q : '0;
  assign ws_fwd_ok = (state_q == S_HOLD) && ready_go && (wen_n == 4'b1111);

  assign debug_wb_pc       = pc_q;
  assign debug_wb_rf_wen   = rf_wen;
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;
endmodule

// File: tb/tb_mycpu_wb_stage.sv
// Directed bench for mycpu_wb_stage: hand-computed expectations checked by immediate assertions.
module tb_mycpu_wb_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic        ws_flush;
  logic [3:0]  rf_wen, debug_wb_rf_wen;
  logic [4:0]  rf_waddr, ws_dest, debug_wb_rf_wnum;
  logic [31:0] rf_wdata, debug_wb_pc, debug_wb_rf_wdata;
  logic        ws_fwd_ok;

  int n_assert = 0;
  int n_fail   = 0;

  mycpu_wb_stage_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) ms_if ();

  mycpu_wb_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk               (clk),
    .rst               (rst),
    .ms                (ms_if.slave),
    .data_rvalid       (data_rvalid),
    .data_rdata        (data_rdata),
    .ws_flush          (ws_flush),
    .rf_wen            (rf_wen),
    .rf_waddr          (rf_waddr),
    .rf_wdata          (rf_wdata),
    .ws_dest           (ws_dest),
    .ws_fwd_ok         (ws_fwd_ok),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction from MEM; it is latched at the next edge.
  task automatic present(input logic [31:0] pc, input logic we, input logic [4:0] dest,
                         input logic [2:0] op, input logic [1:0] a, input logic [31:0] res);
    ms_if.ms_to_ws_valid = 1'b1;
    ms_if.ms_pc          = pc;
    ms_if.ms_gr_we       = we;
    ms_if.ms_dest        = dest;
    ms_if.ms_ld_op       = op;
    ms_if.ms_addr_low    = a;
    ms_if.ms_result      = res;
  endtask

  task automatic send(input logic [31:0] pc, input logic we, input logic [4:0] dest,
                      input logic [2:0] op, input logic [1:0] a, input logic [31:0] res);
    present(pc, we, dest, op, a, res);
    cyc();
    ms_if.ms_to_ws_valid = 1'b0;
  endtask

  // Load in HOLD: deliver the read word this cycle and check the resulting write.
  task automatic load_resp(input string tag, input logic [31:0] rdata,
                           input logic [3:0] wen, input logic [31:0] wdata, input logic fwd);
    data_rvalid = 1'b1;
    data_rdata  = rdata;
    #1;
    chk({tag, "_wen"},   rf_wen, wen);
    chk({tag, "_wdata"}, rf_wdata, wdata);
    chk({tag, "_fwd"},   ws_fwd_ok, fwd);
    cyc();
    data_rvalid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; data_rvalid = 1'b0; data_rdata = '0; ws_flush = 1'b0;
    present(32'h0, 1'b0, 5'd0, 3'd0, 2'd0, 32'h0);
    ms_if.ms_to_ws_valid = 1'b0;
    cyc(); cyc();
    chk("rst_wen",   rf_wen, 4'b0000);
    chk("rst_wnum",  rf_waddr, 5'd0);
    chk("rst_wdata", rf_wdata, 32'h0);
    chk("rst_dest",  ws_dest, 5'd0);
    chk("rst_fwd",   ws_fwd_ok, 1'b0);
    chk("rst_pc",    debug_wb_pc, 32'h0);
    chk("rst_dwen",  debug_wb_rf_wen, 4'b0000);
    chk("rst_allow", ms_if.ws_allowin, 1'b1);
    rst = 1'b1;
    cyc();

    // Non-load, one-cycle latency
    send(32'hBFC0_0100, 1'b1, 5'd5, 3'd0, 2'd0, 32'h1234_5678);
    #1;
    chk("alu_wen",   rf_wen, 4'b1111);
    chk("alu_wnum",  rf_waddr, 5'd5);
    chk("alu_wdata", rf_wdata, 32'h1234_5678);
    chk("alu_pc",    debug_wb_pc, 32'hBFC0_0100);
    chk("alu_dwd",   debug_wb_rf_wdata, 32'h1234_5678);
    chk("alu_dest",  ws_dest, 5'd5);
    chk("alu_fwd",   ws_fwd_ok, 1'b1);
    cyc();
    chk("alu_idle_wen",  rf_wen, 4'b0000);
    chk("alu_hold_data", rf_wdata, 32'h1234_5678);

    // LB a=3 with a 3-cycle stall
    send(32'hBFC0_0104, 1'b1, 5'd7, 3'd1, 2'd3, 32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lb_stall_allow", ms_if.ws_allowin, 1'b0);
      chk("lb_stall_wen",   rf_wen, 4'b0000);
      chk("lb_stall_fwd",   ws_fwd_ok, 1'b0);
      chk("lb_stall_dest",  ws_dest, 5'd7);
      cyc();
    end
    #1;
    chk("lb_allow_resp", ms_if.ws_allowin, 1'b0);
    data_rvalid = 1'b1; data_rdata = 32'h80FF_0011; #1;
    chk("lb_allow_ret", ms_if.ws_allowin, 1'b1);
    chk("lb_wnum", rf_waddr, 5'd7);
    data_rvalid = 1'b0;
    load_resp("lb", 32'h80FF_0011, 4'b1111, 32'hFFFF_FF80, 1'b1);

    send(32'hBFC0_0108, 1'b1, 5'd7, 3'd2, 2'd3, 32'h0);
    load_resp("lbu", 32'h80FF_0011, 4'b1111, 32'h0000_0080, 1'b1);
    send(32'hBFC0_010C, 1'b1, 5'd8, 3'd3, 2'd2, 32'h0);
    load_resp("lh", 32'h8001_1234, 4'b1111, 32'hFFFF_8001, 1'b1);
    send(32'hBFC0_0110, 1'b1, 5'd8, 3'd4, 2'd3, 32'h0);
    load_resp("lhu", 32'h8001_1234, 4'b1111, 32'h0000_8001, 1'b1);
    send(32'hBFC0_0114, 1'b1, 5'd9, 3'd5, 2'd1, 32'h0);
    load_resp("lw", 32'hAABB_CCDD, 4'b1111, 32'hAABB_CCDD, 1'b1);
    send(32'hBFC0_0118, 1'b1, 5'd9, 3'd6, 2'd1, 32'h0);
    load_resp("lwl1", 32'hAABB_CCDD, 4'b1100, 32'hCCDD_0000, 1'b0);
    send(32'hBFC0_011C, 1'b1, 5'd9, 3'd6, 2'd3, 32'h0);
    load_resp("lwl3", 32'hAABB_CCDD, 4'b1111, 32'hAABB_CCDD, 1'b1);
    send(32'hBFC0_0120, 1'b1, 5'd9, 3'd7, 2'd2, 32'h0);
    load_resp("lwr2", 32'hAABB_CCDD, 4'b0011, 32'h0000_AABB, 1'b0);
    send(32'hBFC0_0124, 1'b1, 5'd9, 3'd7, 2'd0, 32'h0);
    load_resp("lwr0", 32'hAABB_CCDD, 4'b1111, 32'hAABB_CCDD, 1'b1);

    // No write for dest=0 or gr_we=0
    send(32'hBFC0_0128, 1'b1, 5'd0, 3'd0, 2'd0, 32'h5555_5555);
    #1;
    chk("d0_wen",  rf_wen, 4'b0000);
    chk("d0_dest", ws_dest, 5'd0);
    cyc();
    send(32'hBFC0_012C, 1'b0, 5'd9, 3'd5, 2'd0, 32'h0);
    #1; chk("nowe_stall_wen", rf_wen, 4'b0000);
    chk("nowe_dest", ws_dest, 5'd0);
    load_resp("nowe", 32'h1111_2222, 4'b0000, 32'h1111_2222, 1'b1);

    // Flush a pending load: DRAIN swallows the next response
    send(32'hBFC0_0130, 1'b1, 5'd3, 3'd5, 2'd0, 32'h0);
    ws_flush = 1'b1; #1;
    chk("fl_wen",   rf_wen, 4'b0000);
    chk("fl_allow", ms_if.ws_allowin, 1'b0);
    cyc();
    ws_flush = 1'b0; #1;
    chk("drain_allow", ms_if.ws_allowin, 1'b0);
    chk("drain_dest",  ws_dest, 5'd0);
    cyc();
    data_rvalid = 1'b1; data_rdata = 32'hCAFE_F00D; #1;
    chk("drain_resp_wen",   rf_wen, 4'b0000);
    chk("drain_resp_allow", ms_if.ws_allowin, 1'b0);
    cyc();
    data_rvalid = 1'b0; #1;
    chk("post_drain_allow", ms_if.ws_allowin, 1'b1);
    chk("post_drain_wen",   rf_wen, 4'b0000);

    // Flush a non-load: straight back to IDLE
    send(32'hBFC0_0134, 1'b1, 5'd4, 3'd0, 2'd0, 32'h7777_7777);
    ws_flush = 1'b1; #1;
    chk("fla_wen",   rf_wen, 4'b0000);
    chk("fla_allow", ms_if.ws_allowin, 1'b0);
    cyc();
    ws_flush = 1'b0; #1;
    chk("fla_idle_allow", ms_if.ws_allowin, 1'b1);

    // Back-to-back A, B, C
    present(32'hBFC0_0200, 1'b1, 5'd10, 3'd0, 2'd0, 32'hAAAA_0001);
    cyc();
    present(32'hBFC0_0204, 1'b1, 5'd11, 3'd0, 2'd0, 32'hBBBB_0002); #1;
    chk("bbA_wen", rf_wen, 4'b1111); chk("bbA_wnum", rf_waddr, 5'd10);
    chk("bbA_wdata", rf_wdata, 32'hAAAA_0001); chk("bbA_allow", ms_if.ws_allowin, 1'b1);
    cyc();
    present(32'hBFC0_0208, 1'b1, 5'd12, 3'd0, 2'd0, 32'hCCCC_0003); #1;
    chk("bbB_wen", rf_wen, 4'b1111); chk("bbB_wnum", rf_waddr, 5'd11);
    chk("bbB_wdata", rf_wdata, 32'hBBBB_0002); chk("bbB_pc", debug_wb_pc, 32'hBFC0_0204);
    cyc();
    ms_if.ms_to_ws_valid = 1'b0; #1;
    chk("bbC_wen", rf_wen, 4'b1111); chk("bbC_wnum", rf_waddr, 5'd12);
    chk("bbC_wdata", rf_wdata, 32'hCCCC_0003);
    cyc();
    chk("bb_end_wen", rf_wen, 4'b0000);

    // Back-to-back with reset in B's cycle
    present(32'hBFC0_0300, 1'b1, 5'd13, 3'd0, 2'd0, 32'h1313_1313);
    cyc();
    present(32'hBFC0_0304, 1'b1, 5'd14, 3'd0, 2'd0, 32'h1414_1414); #1;
    chk("rsA_wdata", rf_wdata, 32'h1313_1313);
    cyc();
    present(32'hBFC0_0308, 1'b1, 5'd15, 3'd0, 2'd0, 32'h1515_1515);
    rst = 1'b0; #1;
    chk("rsB_wdata", rf_wdata, 32'h1414_1414);
    cyc();
    ms_if.ms_to_ws_valid = 1'b0; rst = 1'b1; #1;
    chk("rs_wen",   rf_wen, 4'b0000);
    chk("rs_wnum",  rf_waddr, 5'd0);
    chk("rs_wdata", rf_wdata, 32'h0);
    chk("rs_pc",    debug_wb_pc, 32'h0);
    chk("rs_dest",  ws_dest, 5'd0);
    chk("rs_fwd",   ws_fwd_ok, 1'b0);
    cyc();
    chk("rs_after1_wen", rf_wen, 4'b0000);
    cyc();
    chk("rs_after2_wen", rf_wen, 4'b0000);
    chk("rs_after2_pc",  debug_wb_pc, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/mycpu_wb_stage.md
Name: mycpu_wb_stage

Overview:
- Write-back stage of the five-stage myCPU pipeline; the only writer of the register file.
- Latches the retiring instruction from MEM and waits for load data from the data SRAM when needed.
- Aligns and extends load data and drives the register file's byte-granular write port (wen[3:0], waddr, wdata) exactly once per retired instruction.
- Also drives the debug trace port and hazard/forwarding status back to ID.

Parameters:
- DATA_WIDTH, 32, register and memory data width (fixed; LWL/LWR byte maths assumes 32)
- ADDR_WIDTH, 5, register number width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-low reset (asserted when 0, sampled on clk rising edge)
- ms_to_ws_valid  in  1  MEM holds a valid instruction
- ms_pc  in  32  instruction PC
- ms_gr_we  in  1  instruction writes a GPR
- ms_dest  in  5  destination register
- ms_ld_op  in  3  000 none, 001 LB, 010 LBU, 011 LH, 100 LHU, 101 LW, 110 LWL, 111 LWR
- ms_addr_low  in  2  load address bits [1:0]
- ms_result  in  32  ALU result (used when ld_op=000)
- data_rvalid  in  1  data SRAM read response valid this cycle
- data_rdata  in  32  data SRAM read word
- ws_flush  in  1  exception flush; kill the instruction in WB
- ws_allowin  out  1  WB can accept from MEM this cycle
- rf_wen  out  4  byte write strobes to register file
- rf_waddr  out  5  write register number
- rf_wdata  out  32  write data, already positioned per byte lane
- ws_dest  out  5  dest of the valid WB instruction with gr_we, else 0 (hazard check)
- ws_fwd_ok  out  1  rf_wdata is final this cycle (forwardable)
- debug_wb_pc  out  32  trace PC
- debug_wb_rf_wen  out  4  equals rf_wen
- debug_wb_rf_wnum  out  5  equals rf_waddr
- debug_wb_rf_wdata  out  32  equals rf_wdata

Behaviour:
- States:
  - IDLE: no valid instruction.
  - HOLD: valid instruction latched.
  - DRAIN: flushed load still owes one response.
- Reset (rst=0 at edge):
  - state=IDLE; all latched fields 0.
  - rf_wen=0000; ws_dest=0; ws_fwd_ok=0; debug_* = 0.
- Accept:
  - ws_allowin = (state==IDLE) || (state==HOLD && ready_go && !ws_flush). In DRAIN, ws_allowin=0.
  - Fields are latched when ms_to_ws_valid && ws_allowin; next state is HOLD, otherwise IDLE if the instruction retired.
- Readiness:
  - ready_go = (ld_op==000) || data_rvalid.
  - Non-loads retire the cycle after latch (1-cycle latency). Loads stall in HOLD until data_rvalid.
- Retire cycle: state==HOLD && ready_go && !ws_flush.
  - rf_wen is nonzero only in the retire cycle, and only if gr_we=1 and dest!=0.
  - In every other cycle rf_wen=0000 and rf_waddr/rf_wdata are don't-care but held stable.
- Load alignment (a = addr_low, little-endian):
  - ld_op=000: wdata=ms_result, wen=1111.
  - LB/LBU: byte a of rdata, sign-/zero-extended, wen=1111.
  - LH/LHU: halfword a[1] of rdata, sign-/zero-extended, wen=1111; a[0] ignored (alignment is checked upstream).
  - LW: wdata=rdata, wen=1111.
  - LWL: wdata = rdata << 8*(3-a); wen by a=0..3: 1000, 1100, 1110, 1111.
  - LWR: wdata = rdata >> 8*a; wen by a=0..3: 1111, 0111, 0011, 0001.
- Forwarding status:
  - ws_fwd_ok=1 in HOLD when ready_go and the instruction is not LWL/LWR with partial wen.
  - Partial merges are not forwardable; ID stalls until the write lands.
- Flush:
  - ws_flush in HOLD with no data_rvalid, ld_op!=000: rf_wen=0000; next state DRAIN.
  - ws_flush in HOLD otherwise: rf_wen=0000; next state IDLE.
  - ws_flush in IDLE or DRAIN: no effect.
- DRAIN: the first data_rvalid is discarded, with no write; next state IDLE.
- data_rvalid in IDLE, or in HOLD with ld_op=000, is ignored.
- Reset has priority over flush, accept and retire. Reset mid-load drops the pending response without draining; the memory side is reset together.

Test Plan:
- Non-load: ms_result=0x12345678, dest=5, gr_we=1 -> one cycle later rf_wen=1111, waddr=5, wdata=0x12345678, debug_wb_pc=ms_pc.
- LB with a=3, rdata=0x80FF_0011, stalled 3 cycles before data_rvalid -> ws_allowin=0 for 3 cycles; then wen=1111, wdata=0xFFFF_FF80. LBU with the same inputs -> wdata=0x0000_0080.
- LWL/LWR sweep with rdata=0xAABBCCDD:
  - LWL a=1 -> wen=1100, wdata=0xCCDD_0000.
  - LWR a=2 -> wen=0011, wdata=0x0000_AABB.
  - Both cases -> ws_fwd_ok=0.
- dest=0 or gr_we=0 -> rf_wen stays 0000 for the whole instruction.
- Load in HOLD, ws_flush before data_rvalid -> DRAIN, ws_allowin=0. The next data_rvalid produces no write; the following cycle ws_allowin=1.
- Back-to-back non-loads A, B, C, one per cycle -> three consecutive single-cycle writes in order. rst=0 in the middle cycle -> all outputs 0 on the next cycle, and no further writes.
